// File: rtl/data_mem_resp.sv
// Fixed-latency word memory responder: accepts one read or write, stalls for a
// programmable number of cycles, then signals completion with a one-cycle Done.
module data_mem_resp #(
    parameter int LATENCY = 4,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_t        state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic [AW-1:0] idx;
    logic [15:0]   wdata;
    logic [15:0]   mem [2**AW];

    logic accepting;
    logic any_req;
    logic req_ok;
    logic finish;

    assign accepting = (state == IDLE) || (state == DONE);
    assign any_req   = Rd | Wr;
    // exactly one operation, word aligned, and no address bits above the array
    assign req_ok    = (Rd ^ Wr) && !Addr[0] && ((Addr >> (AW + 1)) == 16'd0);
    assign finish    = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            idx     <= '0;
            wdata   <= 16'd0;
            Done    <= 1'b0;
            Stall   <= 1'b0;
            Err     <= 1'b0;
            DataOut <= 16'd0;
        end else begin
            Done    <= 1'b0;
            Stall   <= 1'b0;
            Err     <= 1'b0;
            DataOut <= 16'd0;
            case (state)
                IDLE, DONE: begin
                    if (accepting && any_req && req_ok) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                        op_wr <= Wr;
                        idx   <= Addr[AW:1];
                        wdata <= DataIn;
                        Stall <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Err   <= any_req;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        if (!op_wr) DataOut <= mem[idx];
                    end else begin
                        cnt   <= cnt - 4'd1;
                        Stall <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // the write commits on the same edge that enters DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 16'd0;
        end else if (finish && op_wr) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: expected completions are queued at issue
// time and compared when Done or Err appears.
module tb_data_mem_resp;

    localparam int LATENCY = 4;
    localparam int AW      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] Addr = 16'd0;
    logic [15:0] DataIn = 16'd0;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        Err;

    data_mem_resp #(.LATENCY(LATENCY), .AW(AW)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .Err(Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model [2**AW];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**AW; i++) model[i] = 16'd0;
    endtask

    task automatic idle(input int n);
        Rd = 1'b0;
        Wr = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_stall", {31'd0, Stall}, 32'd0);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle (valid)
    // or of the Err cycle (invalid), with request inputs deasserted.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] din, input string tag, input bit toggle);
        exp_t x;
        bit   ok;
        ok = (rd ^ wr) && !addr[0] && (addr[15:9] == 7'd0);
        Rd = rd;
        Wr = wr;
        Addr = addr;
        DataIn = din;
        x.tag    = tag;
        x.is_err = !ok;
        x.data   = (ok && rd) ? model[addr[8:1]] : 16'h0000;
        sb.push_back(x);
        if (ok && wr) model[addr[8:1]] = din;
        if (!ok) begin
            @(negedge clk);
            Rd = 1'b0;
            Wr = 1'b0;
            check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
            return;
        end
        for (int c = 1; c < LATENCY; c++) begin
            @(negedge clk);
            check({tag, "_stall"}, {31'd0, Stall}, 32'd1);
            if (toggle && c < LATENCY - 1) begin
                Addr   = addr ^ 16'h0002;
                Wr     = c[0];
                Rd     = 1'b0;
                DataIn = 16'hDEAD;
            end else begin
                Rd = 1'b0;
                Wr = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "_stall_end"}, {31'd0, Stall}, 32'd0);
        check({tag, "_done_cycle"}, {31'd0, Done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (Done || Err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, Done, Err}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.tag, "_err"}, {31'd0, Err}, {31'd0, mon_e.is_err});
                    check({mon_e.tag, "_done"}, {31'd0, Done}, {31'd0, !mon_e.is_err});
                    if (!mon_e.is_err)
                        check({mon_e.tag, "_data"}, {16'd0, DataOut}, {16'd0, mon_e.data});
                end
            end else begin
                check("dataout_idle", {16'd0, DataOut}, 32'd0);
            end
        end
    end

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        check("rst_dataout", {16'd0, DataOut}, 32'd0);
        rst = 1'b1;
        idle(2);

        issue(1'b1, 1'b0, 16'h0010, 16'h0000, "rd_after_reset", 1'b0);
        idle(1);

        // write then read of the same word presented in the DONE cycle
        issue(1'b0, 1'b1, 16'h0020, 16'hBEEF, "wr_beef", 1'b0);
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, "rd_b2b", 1'b0);
        idle(1);

        issue(1'b1, 1'b0, 16'h0021, 16'h0000, "err_odd", 1'b0);
        issue(1'b1, 1'b1, 16'h0002, 16'h7777, "err_both", 1'b0);
        issue(1'b1, 1'b0, 16'h0400, 16'h0000, "err_range", 1'b0);
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, "rd_after_err", 1'b0);
        issue(1'b1, 1'b0, 16'h0002, 16'h0000, "rd_0002", 1'b0);
        idle(1);

        // inputs wiggle during BUSY; the captured request must govern
        issue(1'b0, 1'b1, 16'h0040, 16'h00AA, "wr_40", 1'b0);
        issue(1'b0, 1'b1, 16'h0042, 16'h5555, "wr_42", 1'b0);
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, "rd_40_toggle", 1'b1);
        issue(1'b1, 1'b0, 16'h0042, 16'h0000, "rd_42", 1'b0);
        idle(1);

        issue(1'b0, 1'b1, 16'h01FE, 16'hFFFF, "wr_top", 1'b0);
        issue(1'b1, 1'b0, 16'h01FE, 16'h0000, "rd_top", 1'b0);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000, "rd_zero", 1'b0);
        idle(1);

        // invalid request arriving in DONE gives Err and drops to IDLE
        issue(1'b0, 1'b1, 16'h0050, 16'h1111, "wr_50", 1'b0);
        issue(1'b1, 1'b0, 16'h0051, 16'h0000, "err_in_done", 1'b0);
        issue(1'b1, 1'b0, 16'h0050, 16'h0000, "rd_50", 1'b0);
        idle(1);

        // reset in the second BUSY cycle aborts the write and clears the array
        Wr = 1'b1;
        Addr = 16'h0030;
        DataIn = 16'h1234;
        @(negedge clk);
        Wr = 1'b0;
        check("abort_busy1", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        check("abort_busy2", {31'd0, Stall}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_stall", {31'd0, Stall}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_dataout", {16'd0, DataOut}, 32'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        idle(6);
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, "rd_30_after_abort", 1'b0);
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, "rd_20_after_reset", 1'b0);
        idle(4);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to Done; legal range 2..15.
REQ-002 Parameter AW, default 8: log2 of word count; array holds 2^AW 16-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-005 Rd  input  1  read request, sampled only in an accepting state.
REQ-006 Wr  input  1  write request, sampled only in an accepting state.
REQ-007 Addr  input  16  byte address; word index = Addr[AW:1].
REQ-008 DataIn  input  16  write data.
REQ-009 DataOut  output  16  read data, valid only while Done=1.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Stall  output  1  responder busy; requester SHALL hold Rd/Wr/Addr/DataIn stable while 1.
REQ-012 Err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; accepting states are IDLE and DONE.
REQ-014 Valid request: exactly one of Rd/Wr is 1, Addr[0]=0, and Addr[15:AW+1]=0.
REQ-015 Valid request in accepting state at edge T: capture Addr, DataIn, op; go to BUSY; load latency counter with LATENCY-2.
REQ-016 BUSY: counter decrements each cycle; at 0, go to DONE; Stall=1 in every BUSY cycle, else 0.
REQ-017 Done=1 exactly in DONE; for a request accepted at edge T, DONE spans the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after the request cycle.
REQ-018 Read: DataOut = array[captured index] during DONE; DataOut=0 in all other cycles.
REQ-019 Write: array[captured index] updated on the edge entering DONE; DataOut=0 during DONE.
REQ-020 DONE with a valid request: accept it (back-to-back), go to BUSY; without one, go to IDLE.
REQ-021 Invalid request (both Rd and Wr, odd address, or out-of-range address) in accepting state: no array access, Err=1 next cycle only, next state IDLE.
REQ-022 Neither Rd nor Wr in accepting state: no effect, Err=0.
REQ-023 Rd/Wr/Addr/DataIn changes during BUSY ignored; captured values govern the operation.
REQ-024 Read in DONE of a write to the same word returns the newly written value.
REQ-025 Maximum throughput: one operation per LATENCY cycles.

Reset
REQ-026 rst=0 immediately forces IDLE, counter=0, Done=0, Stall=0, Err=0, DataOut=0, and every array word to 0.
REQ-027 Reset during BUSY aborts the operation; a pending write is discarded; no Done is produced.
REQ-028 The first edge after rst returns to 1 samples requests normally.

Verification (LATENCY=4, AW=8)
REQ-029 After reset, Rd=1 with Addr=0x0010 -> Stall=1 for 3 cycles, then Done=1 with DataOut=0x0000 for 1 cycle.
REQ-030 Wr=1, Addr=0x0020, DataIn=0xBEEF, then Rd=1 with Addr=0x0020 presented in the DONE cycle -> second Done arrives 4 cycles later with DataOut=0xBEEF, and no IDLE cycle occurs between the two operations.
REQ-031 Rd=1 with Addr=0x0021; Rd=Wr=1 with Addr=0x0002; Rd=1 with Addr=0x0400 -> each gives Err=1 for 1 cycle, Stall=0, Done=0, and the array is unchanged.
REQ-032 Wr to 0x0030 with DataIn=0x1234, then rst pulled low during the 2nd BUSY cycle -> no Done; a later Rd of 0x0030 returns 0x0000.
REQ-033 During BUSY of Rd 0x0040 (array 0x00AA), Addr toggles to 0x0042 and Wr pulses -> Done returns 0x00AA and word 0x0042 is unchanged.
REQ-034 Wr to 0x01FE with 0xFFFF, then Rd 0x01FE -> returns 0xFFFF; Rd 0x0000 returns 0x0000, showing no index aliasing.
